// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush controller for a 5-stage pipeline with load-use,
// ID-stage redirect and variable-latency data-memory handshake, plus perf counters.
module pipeline_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMWrite_o,
  output logic             MEMWBBubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2, ERROR = 2'd3;
  logic [1:0]  state, state_nxt;
  logic [31:0] wait_cnt;
  logic        memop, loaduse, active, frozen, adv, timeout;
  assign memop   = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign loaduse = IDEX_MemRead_i & (IDEX_Rt_i != 5'd0) &
                   ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i));
  assign active  = (state == RUN) | (state == MEM_WAIT);
  // The whole pipeline freezes while a data access is outstanding.
  assign frozen  = active & ~dmem_ack_i & (memop | (state == MEM_WAIT));
  assign adv     = active & ~frozen;
  assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt + 32'd1 >= 32'(MEM_TIMEOUT));
  assign dmem_req_o    = frozen | (adv & memop);
  assign PCWrite_o     = adv & ~loaduse;
  assign IFIDWrite_o   = adv & ~loaduse;
  assign IFIDFlush_o   = adv & ~loaduse & (Branch_taken_i | Jump_i);
  assign IDEXBubble_o  = adv & loaduse;
  assign EXMEMWrite_o  = adv;
  assign MEMWBBubble_o = frozen;
  assign err_o         = state == ERROR;
  always_comb begin
    state_nxt = state == IDLE                ? (start_i ? RUN : IDLE) :
                state == ERROR               ? ERROR :
                (state == RUN) && frozen     ? MEM_WAIT :
                (state == MEM_WAIT) && frozen ? (timeout ? ERROR : MEM_WAIT) :
                start_i                      ? RUN : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= ((state == RUN) && frozen)      ? 32'd1 :
                  ((state == MEM_WAIT) && frozen) ? wait_cnt + 32'd1 : 32'd0;
      if (active & ~PCWrite_o & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (IFIDFlush_o & ~&flush_cnt_o) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed table plus randomized run against a cycle-level reference model;
// a second instance with 2-bit counters and no timeout exercises saturation.
module tb_pipeline_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic start, idex_mr, br, jmp, exmr, exmw, ack;
  logic [4:0] idex_rt, rs, rt;
  logic req0, pcw0, ifw0, fl0, idb0, exw0, mwb0, err0;
  logic req1, pcw1, ifw1, fl1, idb1, exw1, mwb1, err1;
  logic [15:0] s0, f0;
  logic [1:0]  s1, f1;
  int nchecks = 0, nerrors = 0;
  always #5 clk = ~clk;

  pipeline_sequencer #(.CNT_W(16), .MEM_TIMEOUT(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .IDEX_MemRead_i(idex_mr), .IDEX_Rt_i(idex_rt),
    .IFID_Rs_i(rs), .IFID_Rt_i(rt), .Branch_taken_i(br), .Jump_i(jmp),
    .EXMEM_MemRead_i(exmr), .EXMEM_MemWrite_i(exmw), .dmem_ack_i(ack),
    .dmem_req_o(req0), .PCWrite_o(pcw0), .IFIDWrite_o(ifw0), .IFIDFlush_o(fl0),
    .IDEXBubble_o(idb0), .EXMEMWrite_o(exw0), .MEMWBBubble_o(mwb0),
    .stall_cnt_o(s0), .flush_cnt_o(f0), .err_o(err0));
  pipeline_sequencer #(.CNT_W(2), .MEM_TIMEOUT(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .IDEX_MemRead_i(idex_mr), .IDEX_Rt_i(idex_rt),
    .IFID_Rs_i(rs), .IFID_Rt_i(rt), .Branch_taken_i(br), .Jump_i(jmp),
    .EXMEM_MemRead_i(exmr), .EXMEM_MemWrite_i(exmw), .dmem_ack_i(ack),
    .dmem_req_o(req1), .PCWrite_o(pcw1), .IFIDWrite_o(ifw1), .IFIDFlush_o(fl1),
    .IDEXBubble_o(idb1), .EXMEMWrite_o(exw1), .MEMWBBubble_o(mwb1),
    .stall_cnt_o(s1), .flush_cnt_o(f1), .err_o(err1));

  wire [7:0] o0 = {req0, pcw0, ifw0, fl0, idb0, exw0, mwb0, err0};
  wire [7:0] o1 = {req1, pcw1, ifw1, fl1, idb1, exw1, mwb1, err1};

  // Reference model: running flag, cycles waited on the current access, sticky error.
  bit running[2], errd[2];
  int waited[2], scnt[2], fcnt[2];
  int tmo[2] = '{4, 0};
  int cmax[2] = '{65535, 3};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      running[i] = 0; errd[i] = 0; waited[i] = 0; scnt[i] = 0; fcnt[i] = 0;
    end
  endtask

  function automatic bit is_active(int i);
    return !errd[i] && (running[i] || waited[i] > 0);
  endfunction

  function automatic logic [7:0] exp_out(int i);
    bit act, memop, lu, fr, ad;
    act   = is_active(i);
    memop = exmr || exmw;
    lu    = idex_mr && idex_rt != 0 && (idex_rt == rs || idex_rt == rt);
    fr    = act && !ack && (memop || waited[i] > 0);
    ad    = act && !fr;
    return {fr || (ad && memop), ad && !lu, ad && !lu, ad && !lu && (br || jmp),
            ad && lu, ad, fr, errd[i]};
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      bit act;
      e = exp_out(i);
      act = is_active(i);
      if (act && !e[6] && scnt[i] < cmax[i]) scnt[i]++;
      if (e[4] && fcnt[i] < cmax[i]) fcnt[i]++;
      if (errd[i]) continue;
      if (!act) running[i] = start;
      else if (e[1]) begin
        if (waited[i] > 0) begin
          waited[i]++;
          if (tmo[i] != 0 && waited[i] >= tmo[i]) errd[i] = 1;
        end else waited[i] = 1;
      end else begin
        waited[i] = 0;
        running[i] = start;
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic s, mr; logic [4:0] xrt, r_s, r_t; logic b, j, er, ew, a;
    logic [7:0] e; int sc, fc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic mr, logic [4:0] xrt, logic [4:0] r_s, logic [4:0] r_t,
                              logic b, logic j, logic er, logic ew, logic a,
                              logic [7:0] e, int sc, int fc);
    vec_t v;
    v.s = s; v.mr = mr; v.xrt = xrt; v.r_s = r_s; v.r_t = r_t; v.b = b; v.j = j;
    v.er = er; v.ew = ew; v.a = a; v.e = e; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic step(input vec_t v, input logic r, input bit use_tbl);
    @(negedge clk);
    rst = r; start = v.s; idex_mr = v.mr; idex_rt = v.xrt; rs = v.r_s; rt = v.r_t;
    br = v.b; jmp = v.j; exmr = v.er; exmw = v.ew; ack = v.a;
    if (r) model_reset();
    #1;
    chk("outs0", o0, exp_out(0));
    chk("stall0", s0, scnt[0]);
    chk("flush0", f0, fcnt[0]);
    chk("outs1", o1, exp_out(1));
    chk("stall1", s1, scnt[1]);
    chk("flush1", f1, fcnt[1]);
    if (use_tbl) begin
      chk("tbl_outs", o0, v.e);
      chk("tbl_stall", s0, v.sc);
      chk("tbl_flush", f0, v.fc);
    end
    @(posedge clk);
    if (!r) model_update();
  endtask

  function automatic vec_t rnd();
    vec_t v;
    v.s = $urandom_range(0, 9) != 0; v.mr = $urandom_range(0, 2) == 0;
    v.xrt = 5'($urandom_range(0, 3)); v.r_s = 5'($urandom_range(0, 3)); v.r_t = 5'($urandom_range(0, 3));
    v.b = $urandom_range(0, 3) == 0; v.j = $urandom_range(0, 7) == 0;
    v.er = $urandom_range(0, 4) == 0; v.ew = $urandom_range(0, 4) == 0;
    v.a = $urandom_range(0, 9) < 6; v.e = '0; v.sc = 0; v.fc = 0;
    return v;
  endfunction

  initial begin
    vec_t z;
    z = mk(0,0,0,0,0,0,0,0,0,0, 8'h00, 0, 0);
    //        s mr xrt rs rt b j er ew a   req pcw ifw fl idb exw mwb err
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 8'b00000000, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 8'b01100100, 0, 0));
    tbl.push_back(mk(1,1,5,5,0,0,0,0,0,0, 8'b00001100, 0, 0));
    tbl.push_back(mk(1,1,0,5,0,0,0,0,0,0, 8'b01100100, 1, 0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0, 8'b01110100, 1, 0));
    tbl.push_back(mk(1,1,7,0,7,1,0,0,0,0, 8'b00001100, 1, 1));
    tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0, 8'b01110100, 2, 1));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0,0, 8'b01110100, 2, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 8'b10000010, 2, 3));
    tbl.push_back(mk(1,0,0,0,0,1,0,0,1,0, 8'b10000010, 3, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 8'b10000010, 4, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1, 8'b11100100, 5, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1, 8'b11100100, 5, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 8'b01100100, 5, 3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 8'b10000010, 5, 3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,1, 8'b11100100, 6, 3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 8'b00000000, 6, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 8'b00000000, 6, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 8'b01100100, 6, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 8'b10000010, 6, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 8'b10000010, 7, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 8'b10000010, 8, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 8'b10000010, 9, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 8'b00000001, 10, 3));
    tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0, 8'b00000001, 10, 3));
    model_reset();
    step(z, 1'b1, 1'b0);
    step(z, 1'b1, 1'b0);
    foreach (tbl[k]) step(tbl[k], 1'b0, 1'b1);
    chk("sat_stall1", s1, 3);
    chk("sat_flush1", f1, 3);
    chk("dut1_waiting_req", req1, 1);
    // dut1 is still waiting on memory here: reset must drop the request without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("req_async_drop", req1, 0);
    chk("err_cleared", err0, 0);
    chk("stall_cleared", s0, 0);
    model_reset();
    @(posedge clk);
    step(z, 1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) step(rnd(), $urandom_range(0, 39) == 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
